// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and the
// clocks-per-bit divider calculation.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  // Clocks per bit, rounded to nearest.
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_receiver_byte_fifo.sv
// First-word-fall-through FIFO with extra-MSB pointers. A push into a full
// FIFO is accepted only when a pop frees a slot in the same cycle.
module byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]                  wr_ptr, rd_ptr;
  logic [DEPTH-1:0][WIDTH-1:0]  mem;
  logic                         do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Head is forced to zero when empty so stale storage never leaks out.
  assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update; pointers wrap naturally through the extra MSB.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; no reset needed since reads are gated by empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: synchronises the line, samples mid-bit, checks the stop
// bit and queues bytes in a small FWFT FIFO with a valid/ready read port.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int DIV   = calc_div(CLK_HZ, BAUD);
  localparam int HALF  = DIV / 2;
  localparam int CW    = $clog2(DIV + 1);
  localparam int BW    = $clog2(DATA_BITS);
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic                 rx_meta, rxs;
  rx_state_t            state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [BW-1:0]        bit_idx, bit_idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 push, ferr_n, ovr_n;
  logic                 fifo_full, fifo_empty;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rxs     <= rx_meta;
    end
  end

  // FSM, bit counter and shift register state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
    end
  end

  // Next-state logic: sample whenever the down-counter reaches zero.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    push      = 1'b0;
    ferr_n    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!rxs) begin
          cnt_n   = HALF_M1;
          state_n = ST_START;
        end
      end
      ST_START: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else if (rxs) begin
          state_n = ST_IDLE;
        end else begin
          cnt_n     = DIV_M1;
          bit_idx_n = '0;
          state_n   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else begin
          shreg_n   = {rxs, shreg[DATA_BITS-1:1]};
          cnt_n     = DIV_M1;
          bit_idx_n = bit_idx + 1'b1;
          if (bit_idx == LAST_BIT) state_n = ST_STOP;
        end
      end
      ST_STOP: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else if (rxs) begin
          // Return at mid-stop so a back-to-back start edge is not missed.
          push    = 1'b1;
          state_n = ST_IDLE;
        end else begin
          ferr_n  = 1'b1;
          state_n = ST_BREAK;
        end
      end
      ST_BREAK: begin
        if (rxs) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // A byte is lost only when full and the consumer is not freeing a slot.
  assign ovr_n = push && fifo_full && !(rx_ready && !fifo_empty);

  // Registered status pulses, aligned with rx_valid rising after a push.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr_n;
      overrun   <= ovr_n;
    end
  end

  assign busy     = (state != ST_IDLE);
  assign rx_valid = !fifo_empty;

  byte_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .wdata  (shreg_n),
    .pop    (rx_ready),
    .rdata  (rx_data),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

endmodule
